// File: rtl/clk_div_gen.sv
// Multi-channel programmable clock divider.
// Each channel counts 0..D-1 and drives a registered divided clock (high for
// ceil(D/2) cycles, then low) plus a one-cycle tick on the last cycle of each
// period. A single pending slot holds a divisor write until the target channel
// reaches a safe point (period end, resync, or idle), so changes never glitch.
//
// Config handshake: a write transfers on any rising edge where cfg_valid and
// cfg_ready are both 1. cfg_ready depends only on registered state, never on
// cfg_valid, and is low during reset and while a write is pending.
module clk_div_gen #(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 16,
    parameter int DEFAULT_DIV = 32,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              resync,
    input  logic              cfg_valid,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO      = DIV_W'(2);
    localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DEFAULT_DIV);

    // Per-channel state
    logic [DIV_W-1:0]  div_q [NUM_CH];
    logic [DIV_W-1:0]  div_d [NUM_CH];
    logic [DIV_W-1:0]  cnt_q [NUM_CH];
    logic [DIV_W-1:0]  cnt_d [NUM_CH];
    logic [NUM_CH-1:0] active_q, active_d;
    logic [NUM_CH-1:0] clk_out_q, clk_out_d;
    logic [NUM_CH-1:0] tick_q, tick_d;

    // Pending write slot and handshake state
    logic              pend_valid_q, pend_valid_d;
    logic [CH_W-1:0]   pend_ch_q, pend_ch_d;
    logic [DIV_W-1:0]  pend_div_q, pend_div_d;
    logic              cfg_err_q, cfg_err_d;
    logic              run_q, run_d;

    logic              cfg_accept;
    logic              cfg_bad;

    assign cfg_ready  = run_q && !pend_valid_q;
    assign cfg_accept = cfg_valid && cfg_ready;
    assign cfg_bad    = (cfg_div < TWO) || (int'(cfg_ch) >= NUM_CH);

    assign cfg_err = cfg_err_q;
    assign clk_out = clk_out_q;
    assign tick    = tick_q;

    // Next-state: channel counters, divisor apply, slot fill, registered outputs
    always_comb begin
        div_d        = div_q;
        cnt_d        = cnt_q;
        active_d     = active_q;
        clk_out_d    = '0;
        tick_d       = '0;
        pend_valid_d = pend_valid_q;
        pend_ch_d    = pend_ch_q;
        pend_div_d   = pend_div_q;
        cfg_err_d    = 1'b0;
        run_d        = 1'b1;

        for (int i = 0; i < NUM_CH; i++) begin
            // Safe apply points: idle channel, or a running channel that is
            // about to restart (period end or resync) and is not being disabled.
            if (pend_valid_q && (int'(pend_ch_q) == i) &&
                (!active_q[i] ||
                 (en[i] && (resync || (cnt_q[i] == div_q[i] - ONE))))) begin
                div_d[i]     = pend_div_q;
                pend_valid_d = 1'b0;
            end

            // Priority: disable > start > resync/wrap > count
            if (!en[i]) begin
                active_d[i] = 1'b0;
                cnt_d[i]    = '0;
            end else if (!active_q[i]) begin
                active_d[i] = 1'b1;
                cnt_d[i]    = '0;
            end else if (resync || (cnt_q[i] == div_q[i] - ONE)) begin
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + ONE;
            end

            // Outputs are registered images of the next state; the high phase
            // is ceil(D/2) cycles so odd divisors get the extra high cycle.
            clk_out_d[i] = active_d[i] && (cnt_d[i] < (div_d[i] - (div_d[i] >> 1)));
            tick_d[i]    = active_d[i] && (cnt_d[i] == div_d[i] - ONE);
        end

        // The slot is empty whenever a write is accepted, so this never
        // collides with the apply above.
        if (cfg_accept) begin
            if (cfg_bad) begin
                cfg_err_d = 1'b1;
            end else begin
                pend_valid_d = 1'b1;
                pend_ch_d    = cfg_ch;
                pend_div_d   = cfg_div;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                div_q[i] <= DIV_INIT;
                cnt_q[i] <= '0;
            end
            active_q     <= '0;
            clk_out_q    <= '0;
            tick_q       <= '0;
            pend_valid_q <= 1'b0;
            pend_ch_q    <= '0;
            pend_div_q   <= '0;
            cfg_err_q    <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            active_q     <= active_d;
            clk_out_q    <= clk_out_d;
            tick_q       <= tick_d;
            pend_valid_q <= pend_valid_d;
            pend_ch_q    <= pend_ch_d;
            pend_div_q   <= pend_div_d;
            cfg_err_q    <= cfg_err_d;
            run_q        <= run_d;
        end
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// Directed bench for clk_div_gen with three channels (so cfg_ch can address a
// non-existent channel). Inputs change on the falling edge; outputs are
// checked on the falling edge, half a cycle after the edge that produced them.
module tb_clk_div_gen;

    localparam int NUM_CH = 3;
    localparam int DIV_W  = 16;
    localparam int CH_W   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_CH-1:0] en;
    logic              resync;
    logic              cfg_valid;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic              cfg_ready;
    logic              cfg_err;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    clk_div_gen #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .resync    (resync),
        .cfg_valid (cfg_valid),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    // Clock
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   d;        // expected divisor of channel 0
    int   ph;       // expected counter of channel 0
    logic exp_rdy;

    typedef struct {
        logic [NUM_CH-1:0] en;
        logic              resync;
        logic [NUM_CH-1:0] exp_clk;
        logic [NUM_CH-1:0] exp_tick;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Check channel 0 against its expected phase for n cycles (others idle)
    task automatic run(input int n, input string name);
        for (int i = 0; i < n; i++) begin
            chk({name, "_clk"},   32'(clk_out), 32'(ph < (d - (d >> 1))));
            chk({name, "_tick"},  32'(tick),    32'(ph == d - 1));
            chk({name, "_ready"}, 32'(cfg_ready), 32'(exp_rdy));
            chk({name, "_err"},   32'(cfg_err), 32'(0));
            step();
            ph = (ph + 1) % d;
        end
    endtask

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        // ch0 D=4, ch1 D=6; rows 6..17 are the 12 cycles after resync
        tbl[0]  = '{3'b011, 1'b0, 3'b011, 3'b000};
        tbl[1]  = '{3'b011, 1'b0, 3'b011, 3'b000};
        tbl[2]  = '{3'b011, 1'b0, 3'b010, 3'b000};
        tbl[3]  = '{3'b011, 1'b0, 3'b000, 3'b001};
        tbl[4]  = '{3'b011, 1'b0, 3'b001, 3'b000};
        tbl[5]  = '{3'b011, 1'b1, 3'b011, 3'b000};
        tbl[6]  = '{3'b011, 1'b0, 3'b011, 3'b000};
        tbl[7]  = '{3'b011, 1'b0, 3'b010, 3'b000};
        tbl[8]  = '{3'b011, 1'b0, 3'b000, 3'b001};
        tbl[9]  = '{3'b011, 1'b0, 3'b001, 3'b000};
        tbl[10] = '{3'b011, 1'b0, 3'b001, 3'b010};
        tbl[11] = '{3'b011, 1'b0, 3'b010, 3'b000};
        tbl[12] = '{3'b011, 1'b0, 3'b010, 3'b001};
        tbl[13] = '{3'b011, 1'b0, 3'b011, 3'b000};
        tbl[14] = '{3'b011, 1'b0, 3'b001, 3'b000};
        tbl[15] = '{3'b011, 1'b0, 3'b000, 3'b000};
        tbl[16] = '{3'b011, 1'b0, 3'b000, 3'b011};
        tbl[17] = '{3'b011, 1'b0, 3'b011, 3'b000};
        tbl[18] = '{3'b001, 1'b1, 3'b001, 3'b000};
        tbl[19] = '{3'b000, 1'b0, 3'b000, 3'b000};

        reset = 1'b1; en = '0; resync = 1'b0;
        cfg_valid = 1'b0; cfg_ch = '0; cfg_div = '0;

        // Reset state
        repeat (3) step();
        chk("rst_clk",   32'(clk_out),   32'(0));
        chk("rst_tick",  32'(tick),      32'(0));
        chk("rst_ready", 32'(cfg_ready), 32'(0));
        chk("rst_err",   32'(cfg_err),   32'(0));
        reset = 1'b0;
        step();
        chk("post_rst_ready", 32'(cfg_ready), 32'(1));
        chk("post_rst_clk",   32'(clk_out),   32'(0));

        // Default divisor on ch0 only
        en = 3'b001;
        step();
        d = 32; ph = 0; exp_rdy = 1'b1;
        run(64, "div32");
        run(10, "div32b");

        // Mid-period write of D=5: current period finishes first
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd5;
        step(); ph = (ph + 1) % d;
        cfg_valid = 1'b0;
        exp_rdy = 1'b0;
        run(21, "hold32");
        d = 5; exp_rdy = 1'b1;
        run(12, "div5");

        // Rejected writes: divisor below 2, channel out of range
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd1;
        step(); ph = (ph + 1) % d;
        chk("err_div_pulse", 32'(cfg_err),   32'(1));
        chk("err_div_ready", 32'(cfg_ready), 32'(1));
        cfg_valid = 1'b0;
        step(); ph = (ph + 1) % d;
        run(3, "after_err_div");
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd7;
        step(); ph = (ph + 1) % d;
        chk("err_ch_pulse", 32'(cfg_err),   32'(1));
        chk("err_ch_ready", 32'(cfg_ready), 32'(1));
        cfg_valid = 1'b0;
        step(); ph = (ph + 1) % d;
        run(10, "div5_kept");

        // Idle channels take a new divisor immediately
        en = 3'b000;
        step();
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd4;
        step();
        cfg_valid = 1'b0;
        chk("idle_w0_pending", 32'(cfg_ready), 32'(0));
        step();
        chk("idle_w0_applied", 32'(cfg_ready), 32'(1));
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd6;
        step();
        cfg_valid = 1'b0;
        chk("idle_w1_pending", 32'(cfg_ready), 32'(0));
        step();
        chk("idle_w1_applied", 32'(cfg_ready), 32'(1));
        chk("idle_clk", 32'(clk_out), 32'(0));

        // Table: two channels, resync and realignment, then disable
        for (int i = 0; i < 20; i++) begin
            en = tbl[i].en; resync = tbl[i].resync;
            step();
            resync = 1'b0;
            chk($sformatf("tbl%0d_clk", i),  32'(clk_out), 32'(tbl[i].exp_clk));
            chk($sformatf("tbl%0d_tick", i), 32'(tick),    32'(tbl[i].exp_tick));
        end

        // Disable during the high phase, then restart from phase 0
        en = 3'b001;
        step();
        d = 4; ph = 0; exp_rdy = 1'b1;
        run(1, "en_pre");
        en = 3'b000;
        step();
        chk("en_off_clk",  32'(clk_out), 32'(0));
        chk("en_off_tick", 32'(tick),    32'(0));
        step();
        chk("en_off2_clk",  32'(clk_out), 32'(0));
        chk("en_off2_tick", 32'(tick),    32'(0));
        en = 3'b001;
        step();
        ph = 0;
        run(8, "re_en");

        // Pending write applied by a mid-period resync
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd6;
        step(); ph = (ph + 1) % d;
        cfg_valid = 1'b0;
        exp_rdy = 1'b0;
        run(1, "pend_rs");
        resync = 1'b1;
        step();
        resync = 1'b0;
        d = 6; ph = 0; exp_rdy = 1'b1;
        run(12, "rs_apply");

        // Resync on the last cycle of a period: tick still seen, restart at 0
        run(5, "rs_end_pre");
        chk("rs_end_tick", 32'(tick), 32'(1));
        resync = 1'b1;
        step();
        resync = 1'b0;
        ph = 0;
        run(6, "rs_end");

        // Reset with a write pending and the counter running
        run(1, "rst_pre");
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd3;
        step(); ph = (ph + 1) % d;
        cfg_valid = 1'b0;
        chk("rst_pend_ready", 32'(cfg_ready), 32'(0));
        reset = 1'b1;
        step();
        chk("midrst_clk",   32'(clk_out),   32'(0));
        chk("midrst_tick",  32'(tick),      32'(0));
        chk("midrst_ready", 32'(cfg_ready), 32'(0));
        chk("midrst_err",   32'(cfg_err),   32'(0));
        step();
        chk("midrst2_clk",   32'(clk_out),   32'(0));
        chk("midrst2_ready", 32'(cfg_ready), 32'(0));
        reset = 1'b0;
        step();
        d = 32; ph = 0; exp_rdy = 1'b1;
        run(40, "after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
